fsk_pkt_deframer: RTL and testbench

Bit-level packet deframer that sits directly downstream of the FSK demodulator. Consumes the demodulated bit stream and its per-bit sample strobe, hunts for a sync word with bounded bit-error tolerance, reads a length byte, emits the payload as bytes, and checks a trailing serial CRC-16. Its output feeds the byte-oriented receive buffer / CPU interface.

---
 rtl/fsk_pkt_deframer_pkg.sv | 24 ++
 rtl/fsk_pkt_deframer_if.sv | 27 ++
 rtl/fsk_pkt_deframer_crc16.sv | 27 ++
 rtl/fsk_pkt_deframer.sv | 182 ++++++++++++++++++
 tb/tb_fsk_pkt_deframer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsk_pkt_deframer_pkg.sv
// Shared types and constants for the FSK packet deframer.
//   state_t     : deframer FSM state encoding
//   CRC_POLY    : CRC-16-CCITT generator polynomial
//   CRC_INIT    : CRC seed loaded on sync lock
//   crc16_step  : one MSB-first serial CRC update
package fsk_pkt_deframer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/fsk_pkt_deframer_if.sv
// Bit-stream input and byte/status output bundle of the deframer.
//   en, bit_in, bit_valid       : driven by master (demod side / bench)
//   byte_out .. busy            : driven by slave (the deframer)
interface fsk_pkt_deframer_if;
  logic       en;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sop;
  logic       eop;
  logic       crc_ok;
  logic [7:0] len_out;
  logic       len_err;
  logic       abort;
  logic       busy;

  modport master (
    output en, bit_in, bit_valid,
    input  byte_out, byte_valid, sop, eop, crc_ok, len_out, len_err, abort, busy
  );

  modport slave (
    input  en, bit_in, bit_valid,
    output byte_out, byte_valid, sop, eop, crc_ok, len_out, len_err, abort, busy
  );
endinterface

// File: rtl/fsk_pkt_deframer_crc16.sv
// Serial CRC-16-CCITT register, MSB-first.
//   clk, rst_n : clock, async active-low reset (reset value CRC_INIT)
//   init       : reload CRC_INIT (wins over bit_en)
//   bit_en     : absorb bit_in this cycle
//   crc        : current register value
module fsk_crc16_serial
  import fsk_pkt_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (bit_en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/fsk_pkt_deframer.sv
// Packet deframer behind the FSK demodulator: sync hunt with Hamming
// tolerance, length byte, LSB-first payload bytes, trailing CRC-16 check.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of fsk_pkt_deframer_if (bit stream in,
//                bytes / sop / eop / crc_ok / len_out / len_err / abort / busy out)
//
// state      | meaning
// -----------+------------------------------------------------
// ST_HUNT    | shifting bits through sr looking for the sync word
// ST_LEN     | assembling the length byte
// ST_PAYLOAD | assembling and emitting payload bytes
// ST_CRC     | absorbing the 16 CRC bits, then eop
module fsk_pkt_deframer
  import fsk_pkt_deframer_pkg::*;
#(
  parameter int unsigned       SYNC_W    = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 32'h8E89BED6,
  parameter int unsigned       MAX_ERR   = 0,
  parameter int unsigned       MAX_LEN   = 64,
  parameter int unsigned       TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  fsk_pkt_deframer_if.slave bus
);

  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT - 1);
  // The oldest sync bit is shifted out before the next compare, so only
  // SYNC_W-1 bits need storing; the compare uses {sr_q, bit_in}.
  localparam logic [SYNC_W-2:0] SR_RELOAD = ~SYNC_WORD[SYNC_W-2:0];

  function automatic int unsigned popcount(input logic [SYNC_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SYNC_W; i++) n += 32'(v[i]);
    return n;
  endfunction

  state_t              state_q, state_d;
  logic [SYNC_W-2:0]   sr_q;
  logic [7:0]          bsr_q;
  logic [2:0]          bit_cnt_q;
  logic [3:0]          crc_cnt_q;
  logic [7:0]          remaining_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [15:0]         crc_q;
  logic [7:0]          byte_out_q, len_out_q;
  logic                byte_valid_q, sop_q, eop_q, crc_ok_q, len_err_q, abort_q;

  logic                acc, busy, byte_done, sync_hit, timeout_hit, crc_zero;
  logic [SYNC_W-1:0]   sr_next;
  logic [7:0]          byte_next;
  logic                crc_init, len_bad, len_good, emit_byte, emit_eop;

  assign acc         = bus.en & bus.bit_valid;
  assign busy        = (state_q != ST_HUNT);
  assign sr_next     = {sr_q, bus.bit_in};
  assign byte_next   = {bus.bit_in, bsr_q[7:1]};
  assign byte_done   = acc && (bit_cnt_q == 3'd7);
  assign sync_hit    = popcount(sr_next ^ SYNC_WORD) <= MAX_ERR;
  assign timeout_hit = bus.en && !bus.bit_valid && busy && (idle_q == '0);
  // Absorbing the transmitted CRC leaves a zero remainder on a clean frame.
  assign crc_zero    = (crc16_step(crc_q, bus.bit_in) == 16'h0000);

  always_comb begin
    state_d   = state_q;
    crc_init  = 1'b0;
    len_bad   = 1'b0;
    len_good  = 1'b0;
    emit_byte = 1'b0;
    emit_eop  = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (acc && sync_hit) begin
          state_d  = ST_LEN;
          crc_init = 1'b1;
        end
      end
      ST_LEN: begin
        if (byte_done) begin
          if (byte_next == 8'd0 || byte_next > 8'(MAX_LEN)) begin
            state_d = ST_HUNT;
            len_bad = 1'b1;
          end else begin
            state_d  = ST_PAYLOAD;
            len_good = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_done) begin
          emit_byte = 1'b1;
          if (remaining_q == 8'd1) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        if (acc && crc_cnt_q == 4'd15) begin
          state_d  = ST_HUNT;
          emit_eop = 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (timeout_hit) state_d = ST_HUNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      sr_q         <= SR_RELOAD;
      bsr_q        <= '0;
      bit_cnt_q    <= '0;
      crc_cnt_q    <= '0;
      remaining_q  <= '0;
      idle_q       <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      crc_ok_q     <= 1'b0;
      len_out_q    <= '0;
      len_err_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_valid_q <= emit_byte;
      sop_q        <= emit_byte && (remaining_q == len_out_q);
      eop_q        <= emit_eop;
      len_err_q    <= len_bad;
      abort_q      <= timeout_hit;

      // Idle timer counts down from TIMEOUT-1; an accepted bit always reloads it.
      if (acc) begin
        idle_q <= IDLE_LOAD;
        if (!busy) begin
          sr_q <= sr_next[SYNC_W-2:0];
        end else begin
          bsr_q     <= byte_next;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end else if (bus.en && busy && idle_q != '0) begin
        idle_q <= idle_q - IDLE_W'(1);
      end

      if (crc_init) bit_cnt_q <= '0;
      if (len_good) begin
        len_out_q   <= byte_next;
        remaining_q <= byte_next;
      end
      if (emit_byte) begin
        byte_out_q  <= byte_next;
        remaining_q <= remaining_q - 8'd1;
        crc_cnt_q   <= '0;
        if (remaining_q == len_out_q) crc_ok_q <= 1'b0;
      end
      if (acc && state_q == ST_CRC) crc_cnt_q <= crc_cnt_q + 4'd1;
      if (emit_eop) crc_ok_q <= crc_zero;
      if (busy && state_d == ST_HUNT) sr_q <= SR_RELOAD;
    end
  end

  fsk_crc16_serial u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (crc_init),
    .bit_en (acc && busy),
    .bit_in (bus.bit_in),
    .crc    (crc_q)
  );

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.sop        = sop_q;
  assign bus.eop        = eop_q;
  assign bus.crc_ok     = crc_ok_q;
  assign bus.len_out    = len_out_q;
  assign bus.len_err    = len_err_q;
  assign bus.abort      = abort_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_fsk_pkt_deframer.sv
// Bench for fsk_pkt_deframer: two instances (MAX_ERR 0 and 2) share one
// stimulus stream; frames are built with a polynomial-division CRC model.
module tb_fsk_pkt_deframer;

  localparam logic [31:0] SYNC = 32'h8E89BED6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;

  always #5 clk = ~clk;

  fsk_pkt_deframer_if ifa();
  fsk_pkt_deframer_if ifb();
  assign ifa.en = en;
  assign ifa.bit_in = bit_in;
  assign ifa.bit_valid = bit_valid;
  assign ifb.en = en;
  assign ifb.bit_in = bit_in;
  assign ifb.bit_valid = bit_valid;

  fsk_pkt_deframer #(.SYNC_W(32), .SYNC_WORD(SYNC), .MAX_ERR(0), .MAX_LEN(64), .TIMEOUT(64))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  fsk_pkt_deframer #(.SYNC_W(32), .SYNC_WORD(SYNC), .MAX_ERR(2), .MAX_LEN(64), .TIMEOUT(64))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [1:0] bv, sp, ep, ok, le, ab, bz;
  logic [7:0] bo [2];
  logic [7:0] lo [2];
  assign bv = {ifb.byte_valid, ifa.byte_valid};
  assign sp = {ifb.sop, ifa.sop};
  assign ep = {ifb.eop, ifa.eop};
  assign ok = {ifb.crc_ok, ifa.crc_ok};
  assign le = {ifb.len_err, ifa.len_err};
  assign ab = {ifb.abort, ifa.abort};
  assign bz = {ifb.busy, ifa.busy};
  assign bo[0] = ifa.byte_out;
  assign bo[1] = ifb.byte_out;
  assign lo[0] = ifa.len_out;
  assign lo[1] = ifb.len_out;

  // Event monitor, sampled on the falling edge.
  logic [7:0] rx_b [2][0:4095];
  int rx_n [2], sop_n [2], sop_pos [2], eop_n [2], le_n [2], ab_n [2], busy_n [2];
  logic ok_eop [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sp[d]) begin
        sop_n[d]++;
        sop_pos[d] = rx_n[d];
      end
      if (bv[d]) begin
        rx_b[d][rx_n[d] & 4095] = bo[d];
        rx_n[d]++;
      end
      if (ep[d]) begin
        eop_n[d]++;
        ok_eop[d] = ok[d];
      end
      if (le[d]) le_n[d]++;
      if (ab[d]) ab_n[d]++;
      if (bz[d]) busy_n[d]++;
    end
  end

  int b_rx [2], b_sop [2], b_eop [2], b_le [2], b_ab [2], b_busy [2];

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      b_rx[d] = rx_n[d];  b_sop[d] = sop_n[d]; b_eop[d] = eop_n[d];
      b_le[d] = le_n[d];  b_ab[d] = ab_n[d];   b_busy[d] = busy_n[d];
    end
  endtask

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame construction
  logic       tx [$];
  logic [7:0] pl [0:255];
  bit         gaps = 1'b0;

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx.push_back(b[i]);
  endtask

  // CRC field = remainder of (M*x^16 + FFFF*x^n) mod G, MSB first.
  task automatic build_frame(input int len, input int errs, input bit corrupt, input bit hdr_only);
    logic [31:0] s;
    bit   used [32];
    int   p, start, n, j, k;
    logic d [$];
    tx.delete();
    for (int i = 0; i < 32; i++) used[i] = 1'b0;
    for (int i = 0; i < 8; i++) tx.push_back(i[0]);
    s = SYNC;
    for (int e = 0; e < errs; e++) begin
      do p = $urandom_range(0, 31); while (used[p]);
      used[p] = 1'b1;
      s[p] = ~s[p];
    end
    for (int i = 31; i >= 0; i--) tx.push_back(s[i]);
    start = tx.size();
    push_byte(8'(len));
    if (hdr_only) return;
    for (int i = 0; i < len; i++) push_byte(pl[i]);
    n = tx.size() - start;
    d.delete();
    for (int i = 0; i < n; i++) d.push_back(tx[start + i]);
    for (int i = 0; i < 16; i++) d[i] = ~d[i];
    for (int i = 0; i < 16; i++) d.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        d[i] = ~d[i]; d[i+4] = ~d[i+4]; d[i+11] = ~d[i+11]; d[i+16] = ~d[i+16];
      end
    end
    for (int i = 0; i < 16; i++) tx.push_back(d[n + i]);
    if (corrupt) begin
      j = $urandom_range(0, len - 1);
      k = $urandom_range(0, 7);
      pl[j][k] = ~pl[j][k];
      tx[start + 8 + 8*j + k] = ~tx[start + 8 + 8*j + k];
    end
  endtask

  task automatic fill_payload(input int len);
    for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
  endtask

  task automatic send_bit(input logic b);
    if (gaps) begin
      int n;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          en = 1'b0; bit_valid = 1'($urandom); bit_in = 1'($urandom);
        end else begin
          en = 1'b1; bit_valid = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    en = 1'b1; bit_valid = 1'b1; bit_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto; i++) send_bit(tx[i]);
  endtask

  task automatic idle(input int n);
    en = 1'b1; bit_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_frame(input int d, input int len, input logic exp_ok);
    string t;
    t = $sformatf("dut%0d", d);
    chk({t, " rx_count"}, 32'(rx_n[d] - b_rx[d]), 32'(len));
    for (int j = 0; j < len; j++)
      chk($sformatf("%s byte%0d", t, j), 32'(rx_b[d][(b_rx[d] + j) & 4095]), 32'(pl[j]));
    chk({t, " sop_count"}, 32'(sop_n[d] - b_sop[d]), 32'd1);
    chk({t, " sop_first"}, 32'(sop_pos[d] - b_rx[d]), 32'd0);
    chk({t, " eop_count"}, 32'(eop_n[d] - b_eop[d]), 32'd1);
    chk({t, " crc_ok"}, 32'(ok_eop[d]), 32'(exp_ok));
    chk({t, " len_out"}, 32'(lo[d]), 32'(len));
    chk({t, " len_err"}, 32'(le_n[d] - b_le[d]), 32'd0);
    chk({t, " abort"}, 32'(ab_n[d] - b_ab[d]), 32'd0);
    chk({t, " busy_end"}, 32'(bz[d]), 32'd0);
  endtask

  task automatic run_frame(input int len, input bit corrupt);
    fill_payload(len);
    build_frame(len, 0, corrupt, 1'b0);
    snap();
    send_range(0, tx.size());
    idle(4);
    check_frame(0, len, !corrupt);
    check_frame(1, len, !corrupt);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s dut%0d", tag, d),
          32'({bo[d], bv[d], sp[d], ep[d], ok[d], lo[d], le[d], ab[d], bz[d]}), 32'd0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, guard, lens [6];

    #2;
    check_zero_outputs("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    // Known frame A5 01 FF with good CRC, then a corrupted copy.
    pl[0] = 8'hA5; pl[1] = 8'h01; pl[2] = 8'hFF;
    build_frame(3, 0, 1'b0, 1'b0);
    snap();
    send_range(0, tx.size());
    idle(4);
    check_frame(0, 3, 1'b1);
    check_frame(1, 3, 1'b1);
    pl[0] = 8'hA5; pl[1] = 8'h01; pl[2] = 8'hFF;
    build_frame(3, 0, 1'b1, 1'b0);
    snap();
    send_range(0, tx.size());
    idle(4);
    check_frame(0, 3, 1'b0);
    check_frame(1, 3, 1'b0);

    // Sync with 1, 2, 3 bit errors: only MAX_ERR=2 locks, and only for <=2.
    for (int errs = 1; errs <= 3; errs++) begin
      int len;
      len = $urandom_range(1, 8);
      fill_payload(len);
      build_frame(len, errs, 1'b0, 1'b0);
      snap();
      send_range(0, tx.size());
      idle(4);
      chk($sformatf("err%0d dut0 rx", errs), 32'(rx_n[0] - b_rx[0]), 32'd0);
      chk($sformatf("err%0d dut0 busy_seen", errs), 32'(busy_n[0] - b_busy[0]), 32'd0);
      if (errs <= 2) begin
        check_frame(1, len, 1'b1);
      end else begin
        chk("err3 dut1 rx", 32'(rx_n[1] - b_rx[1]), 32'd0);
        chk("err3 dut1 busy_seen", 32'(busy_n[1] - b_busy[1]), 32'd0);
      end
    end

    // Illegal lengths 0x00 and 0x41.
    run_frame(5, 1'b0);
    for (int t = 0; t < 2; t++) begin
      int lb;
      lb = (t == 0) ? 0 : 8'h41;
      build_frame(lb, 0, 1'b0, 1'b1);
      snap();
      send_range(0, tx.size());
      idle(4);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("len%0h dut%0d len_err", lb, d), 32'(le_n[d] - b_le[d]), 32'd1);
        chk($sformatf("len%0h dut%0d rx", lb, d), 32'(rx_n[d] - b_rx[d]), 32'd0);
        chk($sformatf("len%0h dut%0d busy", lb, d), 32'(bz[d]), 32'd0);
        chk($sformatf("len%0h dut%0d len_out_held", lb, d), 32'(lo[d]), 32'd5);
      end
    end

    // Timeout after one payload byte; en randomly toggled while idle.
    fill_payload(4);
    build_frame(4, 0, 1'b0, 1'b0);
    snap();
    send_range(0, 8 + 32 + 16);
    bit_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < 64 && guard < 2000) begin
      en = 1'($urandom);
      @(posedge clk); #1;
      guard++;
      if (en) begin
        k++;
        if (k == 63) begin
          chk("timeout early dut0", 32'(ab[0]), 32'd0);
          chk("timeout early dut1", 32'(ab[1]), 32'd0);
        end
        if (k == 64) begin
          chk("timeout fire dut0", 32'(ab[0]), 32'd1);
          chk("timeout fire dut1", 32'(ab[1]), 32'd1);
        end
      end
    end
    chk("timeout bound", 32'(k), 32'd64);
    idle(3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("timeout dut%0d rx", d), 32'(rx_n[d] - b_rx[d]), 32'd1);
      chk($sformatf("timeout dut%0d byte0", d), 32'(rx_b[d][b_rx[d] & 4095]), 32'(pl[0]));
      chk($sformatf("timeout dut%0d abort_count", d), 32'(ab_n[d] - b_ab[d]), 32'd1);
      chk($sformatf("timeout dut%0d eop", d), 32'(eop_n[d] - b_eop[d]), 32'd0);
      chk($sformatf("timeout dut%0d busy", d), 32'(bz[d]), 32'd0);
    end
    run_frame(7, 1'b0);

    // Reset mid-payload.
    fill_payload(10);
    build_frame(10, 0, 1'b0, 1'b0);
    send_range(0, 8 + 32 + 8 + 24);
    snap();
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midreset_outputs");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_range(8 + 32 + 8 + 24, tx.size());
    idle(80);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midreset dut%0d eop", d), 32'(eop_n[d] - b_eop[d]), 32'd0);
      chk($sformatf("midreset dut%0d abort", d), 32'(ab_n[d] - b_ab[d]), 32'd0);
      chk($sformatf("midreset dut%0d busy", d), 32'(bz[d]), 32'd0);
    end
    run_frame(2, 1'b0);

    // Random frames across en gaps, including length boundaries 1 and MAX_LEN.
    gaps = 1'b1;
    lens[0] = 1;
    lens[1] = 64;
    for (int i = 2; i < 6; i++) lens[i] = $urandom_range(1, 64);
    for (int i = 0; i < 6; i++) run_frame(lens[i], (i == 4));
    gaps = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
